// File: rtl/interleaver_pkg.sv
// Shared types and defaults for the turbo interleaver ping-pong controller.
// Holds the FSM state enums, the default block lengths and the length-select helper.
package interleaver_pkg;

    localparam int unsigned K_SMALL_DEF = 1056;
    localparam int unsigned K_LARGE_DEF = 6144;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_WAIT
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DRAIN,
        R_DONE
    } rd_state_t;

    function automatic int unsigned blk_len(
        input logic        sel,
        input int unsigned k_small = K_SMALL_DEF,
        input int unsigned k_large = K_LARGE_DEF
    );
        return sel ? k_large : k_small;
    endfunction

endpackage

// File: rtl/ilv_bank_ctr.sv
// Loadable up-counter with clear and enable; at_term flags count == term_val.
// Clear has priority over load, load over increment.
module ilv_bank_ctr #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              en,
    input  logic [ADDR_W-1:0] term_val,
    output logic [ADDR_W-1:0] count,
    output logic              at_term
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + ADDR_W'(1);
        end
    end

    assign at_term = (count == term_val);

endmodule

// File: rtl/interleaver_pingpong_ctrl.sv
// Ping-pong bank controller: fills one interleaver RAM bank from the CRC stage
// while the other bank is drained towards the permutation address unit.
module interleaver_pingpong_ctrl
    import interleaver_pkg::*;
#(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned K_SMALL = K_SMALL_DEF,
    parameter int unsigned K_LARGE = K_LARGE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_start,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              blk_sel,
    input  logic              mode,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              out_ready,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_cnt,
    output logic [ADDR_W-1:0] rd_len,
    output logic              rd_mode,
    output logic              rd_first,
    output logic              rd_last,
    output logic              done,
    output logic              short_blk,
    output logic              proto_err
);

    wr_state_t         w_state, w_next;
    rd_state_t         r_state, r_next;

    logic [1:0]        full;
    logic [ADDR_W-1:0] bank_len [2];
    logic [1:0]        mode_tag;

    logic [ADDR_W-1:0] cur_k, k_sel, k_act;
    logic              cur_mode, mode_act;
    logic [ADDR_W-1:0] wr_cnt, rd_cnt_q, rd_len_q;
    logic              rd_mode_q;
    logic              wr_term, rd_term;
    logic              wr_close, rd_close;
    logic              short_q, proto_q;

    // The first beat of a block is judged against the live blk_sel/mode,
    // later beats against the values latched on that first beat.
    assign k_sel    = ADDR_W'(blk_len(blk_sel, K_SMALL, K_LARGE));
    assign k_act    = (w_state == W_IDLE) ? k_sel : cur_k;
    assign mode_act = (w_state == W_IDLE) ? mode  : cur_mode;

    ilv_bank_ctr #(.ADDR_W(ADDR_W)) u_wr_ctr (
        .clk      (clk),
        .reset    (reset),
        .clear    (wr_close),
        .load     (1'b0),
        .load_val ('0),
        .en       (wr_en),
        .term_val (k_act - ADDR_W'(1)),
        .count    (wr_cnt),
        .at_term  (wr_term)
    );

    ilv_bank_ctr #(.ADDR_W(ADDR_W)) u_rd_ctr (
        .clk      (clk),
        .reset    (reset),
        .clear    (rd_close),
        .load     (1'b0),
        .load_val ('0),
        .en       (rd_en),
        .term_val (rd_len_q - ADDR_W'(1)),
        .count    (rd_cnt_q),
        .at_term  (rd_term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: begin
                if (wr_close)   w_next = full[~wr_bank] ? W_WAIT : W_IDLE;
                else if (wr_en) w_next = W_FILL;
            end
            W_FILL: begin
                if (wr_close)   w_next = full[~wr_bank] ? W_WAIT : W_IDLE;
            end
            W_WAIT: begin
                if (!full[wr_bank]) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (full[rd_bank]) r_next = R_DRAIN;
            R_DRAIN: if (rd_close)      r_next = R_DONE;
            R_DONE:  r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (w_state != W_WAIT);
        wr_en    = in_valid & in_ready &
                   ((w_state == W_FILL) | ((w_state == W_IDLE) & in_start));
        wr_close = wr_en & (in_last | wr_term);
        rd_en    = (r_state == R_DRAIN) & out_ready;
        rd_close = rd_en & rd_term;
        done     = (r_state == R_DONE);
    end

    // Write-close and read-free always address opposite banks, so both
    // updates to full[] can land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full        <= '0;
            bank_len[0] <= '0;
            bank_len[1] <= '0;
            mode_tag    <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            cur_k       <= '0;
            cur_mode    <= 1'b0;
            rd_len_q    <= '0;
            rd_mode_q   <= 1'b0;
            short_q     <= 1'b0;
            proto_q     <= 1'b0;
        end else begin
            short_q <= wr_close & in_last & ~wr_term;
            proto_q <= (w_state == W_IDLE) & in_valid & ~in_start;
            if ((w_state == W_IDLE) && wr_en) begin
                cur_k    <= k_sel;
                cur_mode <= mode;
            end
            if (wr_close) begin
                full[wr_bank]     <= 1'b1;
                bank_len[wr_bank] <= wr_cnt + ADDR_W'(1);
                mode_tag[wr_bank] <= mode_act;
                wr_bank           <= ~wr_bank;
            end
            if ((r_state == R_IDLE) && full[rd_bank]) begin
                rd_len_q  <= bank_len[rd_bank];
                rd_mode_q <= mode_tag[rd_bank];
            end
            if (rd_close) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    assign wr_addr   = wr_cnt;
    assign rd_cnt    = rd_cnt_q;
    assign rd_len    = rd_len_q;
    assign rd_mode   = rd_mode_q;
    assign rd_first  = rd_en & (rd_cnt_q == '0);
    assign rd_last   = rd_en & rd_term;
    assign short_blk = short_q;
    assign proto_err = proto_q;

endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// Directed-plus-random bench for interleaver_pingpong_ctrl against a block-queue model:
// written blocks are queued as {length, mode, bank} and every read beat is checked against the head.
module tb_interleaver_pingpong_ctrl;

    localparam int unsigned AW = 13;
    localparam int unsigned KS = 1056;
    localparam int unsigned KL = 6144;
    localparam int unsigned WAIT_MAX = 20000;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_start, in_valid, in_last, blk_sel, mode;
    logic          in_ready, wr_en, wr_bank;
    logic [AW-1:0] wr_addr;
    logic          out_ready;
    logic          rd_en, rd_bank;
    logic [AW-1:0] rd_cnt, rd_len;
    logic          rd_mode, rd_first, rd_last, done, short_blk, proto_err;

    always #5 clk = ~clk;

    interleaver_pingpong_ctrl #(.ADDR_W(AW), .K_SMALL(KS), .K_LARGE(KL)) dut (
        .clk(clk), .reset(reset),
        .in_start(in_start), .in_valid(in_valid), .in_last(in_last),
        .blk_sel(blk_sel), .mode(mode),
        .in_ready(in_ready), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .out_ready(out_ready), .rd_en(rd_en), .rd_bank(rd_bank), .rd_cnt(rd_cnt),
        .rd_len(rd_len), .rd_mode(rd_mode), .rd_first(rd_first), .rd_last(rd_last),
        .done(done), .short_blk(short_blk), .proto_err(proto_err)
    );

    typedef struct {
        int unsigned len;
        logic        mode;
        logic        bank;
    } blk_t;

    blk_t        rq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        wbank = 1'b0;
    int unsigned wpos = 0;
    logic        cur_mode = 1'b0;
    logic        pend_short = 1'b0;
    logic        pend_proto = 1'b0;
    logic        last_prev = 1'b0;
    int unsigned rd_idx = 0;
    int          stalls = 0;
    int          dones = 0;
    int          closed = 0;
    bit          rand_rdy = 1'b0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input logic obs, input logic exp, input string tag);
        chk(32'(obs), 32'(exp), tag);
    endtask

    // Read-side scoreboard and one-cycle pulse checks, every cycle.
    always @(negedge clk) begin
        if (reset) begin
            rd_idx    = 0;
            last_prev = 1'b0;
        end else begin
            chk1(done, last_prev, "done");
            if (done === 1'b1) dones++;
            chk1(short_blk, pend_short, "short_blk");
            pend_short = 1'b0;
            chk1(proto_err, pend_proto, "proto_err");
            pend_proto = 1'b0;
            last_prev = 1'b0;
            if (rd_en === 1'b1) begin
                if (rq.size() == 0) begin
                    chk1(rd_en, 1'b0, "rd_unexpected");
                end else begin
                    chk1(rd_bank, rq[0].bank, "rd_bank");
                    chk(32'(rd_cnt), rd_idx, "rd_cnt");
                    chk(32'(rd_len), rq[0].len, "rd_len");
                    chk1(rd_mode, rq[0].mode, "rd_mode");
                    chk1(rd_first, rd_idx == 0, "rd_first");
                    chk1(rd_last, rd_idx == rq[0].len - 1, "rd_last");
                    rd_idx++;
                    if (rd_idx == rq[0].len) begin
                        void'(rq.pop_front());
                        rd_idx    = 0;
                        last_prev = 1'b1;
                    end
                end
            end
        end
    end

    // One write beat, held until accepted; starts and ends at posedge+1.
    task automatic beat(input logic st, input logic lst, input logic s, input logic m,
                        input int unsigned k);
        int unsigned waits = 0;
        logic        close;
        blk_t        b;
        in_valid = 1'b1; in_start = st; in_last = lst; blk_sel = s; mode = m;
        @(negedge clk);
        while (in_ready !== 1'b1 && waits < WAIT_MAX) begin
            waits++;
            stalls++;
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 1'b1;
            @(negedge clk);
        end
        chk1(in_ready, 1'b1, "in_ready_timeout");
        if (waits >= WAIT_MAX) begin
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $fatal(1, "FAIL in_ready_timeout: write side never became ready");
        end
        chk1(wr_en, 1'b1, "wr_en");
        chk(32'(wr_addr), wpos, "wr_addr");
        chk1(wr_bank, wbank, "wr_bank");
        close = lst || (wpos == k - 1);
        @(posedge clk); #1;
        pend_short = lst && (wpos != k - 1);
        if (close) begin
            b.len = wpos + 1; b.mode = cur_mode; b.bank = wbank;
            rq.push_back(b);
            wbank = ~wbank;
            wpos  = 0;
            closed++;
        end else begin
            wpos++;
        end
        in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // n beats; ends by count when n == K, otherwise by in_last on beat n-1.
    task automatic send_block(input logic sel, input logic md, input int unsigned n, input bit noisy);
        int unsigned k;
        logic st, s, m;
        k = sel ? KL : KS;
        cur_mode = md;
        for (int unsigned i = 0; i < n; i++) begin
            if (noisy && i > 0 && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            st = (i == 0) ? 1'b1 : (noisy && $urandom_range(0, 15) == 0);
            s  = (i == 0 || !noisy) ? sel : 1'($urandom_range(0, 1));
            m  = (i == 0 || !noisy) ? md  : 1'($urandom_range(0, 1));
            beat(st, (i == n - 1) && (n < k), s, m, k);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (rq.size() != 0 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        chk1(rq.size() == 0, 1'b1, "drain_timeout");
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs();
        chk1(in_ready, 1'b1, "rst_in_ready");
        chk1(wr_en, 1'b0, "rst_wr_en");
        chk(32'(wr_addr), 0, "rst_wr_addr");
        chk1(wr_bank, 1'b0, "rst_wr_bank");
        chk1(rd_en, 1'b0, "rst_rd_en");
        chk1(rd_bank, 1'b0, "rst_rd_bank");
        chk(32'(rd_cnt), 0, "rst_rd_cnt");
        chk(32'(rd_len), 0, "rst_rd_len");
        chk1(rd_mode, 1'b0, "rst_rd_mode");
        chk1(rd_first, 1'b0, "rst_rd_first");
        chk1(rd_last, 1'b0, "rst_rd_last");
        chk1(done, 1'b0, "rst_done");
        chk1(short_blk, 1'b0, "rst_short_blk");
        chk1(proto_err, 1'b0, "rst_proto_err");
    endtask

    initial begin
        int          n;
        int unsigned len;
        logic        sel, md;

        reset = 1'b1;
        in_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        blk_sel = 1'b0; mode = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;

        // Full small block; first read beat two cycles after the closing edge.
        send_block(1'b0, 1'b0, KS, 1'b0);
        @(negedge clk);
        chk1(rd_en, 1'b0, "rd_latency_early");
        @(negedge clk);
        chk1(rd_en, 1'b1, "rd_latency");
        chk1(rd_first, 1'b1, "rd_first_latency");
        wait_drain();
        chk(dones, 1, "small_done_count");

        // Back-to-back large blocks with opposite mode tags; writer never stalls.
        stalls = 0;
        send_block(1'b1, 1'b0, KL, 1'b0);
        idle_cycles(4);
        send_block(1'b1, 1'b1, KL, 1'b0);
        chk(stalls, 0, "large_no_stall");
        wait_drain();

        // Read stall: two fills with out_ready low leave the writer waiting.
        out_ready = 1'b0;
        send_block(1'b0, 1'b0, KS, 1'b0);
        send_block(1'b0, 1'b1, KS, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1(in_ready, 1'b0, "wait_hold");
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(rd_en === 1'b1 && rd_last === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk1(rd_last, 1'b1, "stall_drain_end");
        chk1(in_ready, 1'b0, "ready_at_clear");
        @(negedge clk);
        chk1(in_ready, 1'b0, "ready_one_after_clear");
        @(negedge clk);
        chk1(in_ready, 1'b1, "ready_rise");
        @(posedge clk); #1;
        send_block(1'b0, 1'b1, $urandom_range(2, KS - 1), 1'b1);
        wait_drain();

        // Early end on beat 99 of a large block.
        send_block(1'b1, 1'($urandom_range(0, 1)), 100, 1'b0);
        wait_drain();
        chk(32'(rd_len), 100, "early_len");

        // Stray beat in idle: dropped and flagged.
        in_valid = 1'b1; in_start = 1'b0;
        @(negedge clk);
        chk1(wr_en, 1'b0, "proto_wr_en");
        chk1(in_ready, 1'b1, "proto_ready");
        @(posedge clk); #1;
        pend_proto = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk(32'(wr_addr), wpos, "proto_addr");
        chk1(wr_bank, wbank, "proto_bank");
        @(posedge clk); #1;

        // Randomized blocks, lengths, gaps and read back-pressure.
        rand_rdy = 1'b1;
        for (int b = 0; b < 8; b++) begin
            sel = 1'($urandom_range(0, 3) == 0);
            md  = 1'($urandom_range(0, 1));
            if (sel) begin
                len = $urandom_range(1, 1200);
            end else begin
                case ($urandom_range(0, 3))
                    0:       len = 1;
                    1:       len = $urandom_range(2, KS - 1);
                    default: len = KS;
                endcase
            end
            send_block(sel, md, len, 1'b1);
            idle_cycles($urandom_range(0, 3));
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset while writing beat 500 and draining the previous block.
        send_block(1'b0, 1'b0, KS, 1'b0);
        cur_mode = 1'b0;
        for (int unsigned i = 0; i < 500; i++) beat(i == 0, 1'b0, 1'b1, 1'b0, KL);
        @(negedge clk);
        chk1(rd_en, 1'b1, "drain_active_at_reset");
        #1;
        reset = 1'b1;
        rq.delete();
        wbank = 1'b0; wpos = 0;
        pend_short = 1'b0; pend_proto = 1'b0;
        closed = 0; dones = 0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk1(in_ready, 1'b1, "ready_after_reset");
        @(posedge clk); #1;
        send_block(1'b0, 1'b1, KS, 1'b0);
        wait_drain();
        chk(dones, closed, "done_count");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
